// File: rtl/herloa_pipe.sv
// herloa_pipe: two-stage pipelined approximate adder (OR-based lower part of width k_eff, exact upper part).
// Optional macro HERLOA_ERR_MON_EN adds the err / err_cnt / err_clr error-monitor ports.
`timescale 1ns/1ps
module herloa_pipe #(
  parameter int N    = 16,
  parameter int KMAX = 11,
  parameter int KW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [KW-1:0] k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  s,
  output logic          cout
`ifdef HERLOA_ERR_MON_EN
  ,
  output logic [N:0]    err,
  output logic [15:0]   err_cnt,
  input  logic          err_clr
`endif
);

  localparam logic [KW-1:0] KMAX_K = KW'(KMAX);

  logic          adv;
  logic [KW-1:0] ke_d;
  logic [N-1:0]  lo_d, ha_d, hb_d;
  logic          c_d, g2;

  logic          v1_q, v2_q;
  logic [KW-1:0] ke1_q;
  logic [N-1:0]  lo1_q, ha1_q, hb1_q;
  logic          c1_q;

  logic [N:0]    cin_vec, up_sum;
  logic [N-1:0]  s_d, s_q;
  logic          cout_d, cout_q;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign adv       = !v2_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v2_q;
  assign s         = s_q;
  assign cout      = cout_q;

  always_comb begin
    ke_d = (k > KMAX_K) ? KMAX_K : k;
    g2   = 1'b0;
    c_d  = 1'b0;
    lo_d = '0;
    ha_d = a;
    hb_d = b;
    for (int i = 0; i < N; i++) begin
      if (i == int'(ke_d) - 2) g2  = a[i] & b[i];
      if (i == int'(ke_d) - 1) c_d = a[i] & b[i];
    end
    // Bits below k_eff-2 are forced high when the k_eff-2 generate fires (error reduction).
    for (int i = 0; i < N; i++) begin
      if (i < int'(ke_d)) begin
        ha_d[i] = 1'b0;
        hb_d[i] = 1'b0;
      end
      if (i < int'(ke_d) - 2)
        lo_d[i] = a[i] | b[i] | g2;
      else if (i == int'(ke_d) - 2)
        lo_d[i] = a[i] | b[i];
      else if (i == int'(ke_d) - 1)
        lo_d[i] = (ke_d == KW'(1)) ? (a[i] | b[i]) : ((a[i] ^ b[i]) | g2);
    end
  end

  // Upper operands have their lower k_eff bits zeroed, so the lower carry enters at bit k_eff.
  always_comb begin
    cin_vec = {{N{1'b0}}, c1_q} << ke1_q;
    up_sum  = {1'b0, ha1_q} + {1'b0, hb1_q} + cin_vec;
    s_d     = up_sum[N-1:0] | lo1_q;
    cout_d  = up_sum[N];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (v1_q) begin
        s_q    <= s_d;
        cout_q <= cout_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      ke1_q <= ke_d;
      lo1_q <= lo_d;
      ha1_q <= ha_d;
      hb1_q <= hb_d;
      c1_q  <= c_d;
    end
  end

`ifdef HERLOA_ERR_MON_EN
  logic [N:0]  ex1_q, approx, err_d, err_q;
  logic [15:0] err_cnt_q;

  always_comb begin
    approx = {cout_d, s_d};
    err_d  = (ex1_q >= approx) ? (ex1_q - approx) : (approx - ex1_q);
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) ex1_q <= {1'b0, a} + {1'b0, b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (adv && v1_q) begin
      err_q <= err_d;
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_cnt_q <= '0;
    end else if (v2_q && out_ready && (err_q != '0) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_herloa_pipe.sv
// tb_herloa_pipe: directed and randomized checks of herloa_pipe against a spec-level arithmetic model.
// Error-monitor ports are exercised when HERLOA_ERR_MON_EN is defined.
`timescale 1ns/1ps
module tb_herloa_pipe;
  localparam int N = 16, KMAX = 11, KW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, cout;
  logic [N-1:0]  a = '0, b = '0, s;
  logic [KW-1:0] k = '0;
`ifdef HERLOA_ERR_MON_EN
  logic [N:0]    err;
  logic [15:0]   err_cnt;
  logic          err_clr = 1'b0;
`endif

  herloa_pipe #(.N(N), .KMAX(KMAX), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .k(k), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout)
`ifdef HERLOA_ERR_MON_EN
    , .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic [N:0]   e;
  } exp_t;

  exp_t q[$];
  int   errs = 0, checks = 0;
  int   cnt_m = 0;
  bit   acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Spec-level model: lower part by the bit rules, upper part as shifted integer add.
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input int kv);
    int          ke;
    logic [31:0] lo, hi, ex, ap;
    logic        g, c;
    exp_t        r;
    ke = (kv > KMAX) ? KMAX : kv;
    lo = '0;
    c  = 1'b0;
    if (ke >= 1) begin
      c = av[ke-1] & bv[ke-1];
      for (int i = 0; i < ke - 1; i++) lo[i] = av[i] | bv[i];
      if (ke == 1) begin
        lo[0] = av[0] | bv[0];
      end else begin
        g = av[ke-2] & bv[ke-2];
        lo[ke-1] = (av[ke-1] ^ bv[ke-1]) | g;
        if (g && ke >= 3) lo = lo | ((32'd1 << (ke - 2)) - 32'd1);
      end
    end
    hi = ((32'(av) >> ke) + (32'(bv) >> ke) + 32'(c)) << ke;
    ap = hi | lo;
    ex = 32'(av) + 32'(bv);
    r.s = ap[N-1:0];
    r.c = ap[N];
    r.e = 17'((ex >= ap) ? (ex - ap) : (ap - ex));
    return r;
  endfunction

  // One cycle: evaluate handshakes against the model, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
`ifdef HERLOA_ERR_MON_EN
      chk("err_cnt", err_cnt, cnt_m);
`endif
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          e = q[0];
          chk("s", s, e.s);
          chk("cout", cout, e.c);
`ifdef HERLOA_ERR_MON_EN
          chk("err", err, e.e);
`endif
          if (out_ready) begin
            void'(q.pop_front());
`ifdef HERLOA_ERR_MON_EN
            if (!err_clr && e.e != 0 && cnt_m != 16'hFFFF) cnt_m++;
`endif
          end
        end
      end
`ifdef HERLOA_ERR_MON_EN
      if (err_clr) cnt_m = 0;
`endif
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(a, b, int'(k)));
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [KW-1:0] kv);
    in_valid = 1'b1;
    a = av;
    b = bv;
    k = kv;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  int c0;

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef HERLOA_ERR_MON_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);

    // 0x00FF + 0x00FF, k=11, with two-cycle latency
    out_ready = 1'b1;
    drive(16'h00FF, 16'h00FF, 4'd11);
    tick();
    idle();
    chk("lat_cycle1_valid", out_valid, 0);
    tick();
    chk("lat_cycle2_valid", out_valid, 1);
    chk("d030_s", s, 16'h00FF);
    chk("d030_cout", cout, 0);
`ifdef HERLOA_ERR_MON_EN
    chk("d030_err", err, 17'h000FF);
`endif
    tick();

    // back-to-back k change
    drive(16'hFFFF, 16'h0001, 4'd11);
    tick();
    drive(16'hFFFF, 16'h0001, 4'd0);
    tick();
    idle();
    chk("d031a_valid", out_valid, 1);
    chk("d031a_s", s, 16'hFFFF);
    chk("d031a_cout", cout, 0);
    tick();
    chk("d031b_valid", out_valid, 1);
    chk("d031b_s", s, 16'h0000);
    chk("d031b_cout", cout, 1);
    tick();

    // error reduction
    c0 = cnt_m;
    drive(16'h0300, 16'h0300, 4'd11);
    tick();
    idle();
    tick();
    chk("d032_s", s, 16'h07FF);
    chk("d032_cout", cout, 0);
`ifdef HERLOA_ERR_MON_EN
    chk("d032_err", err, 17'h001FF);
`endif
    tick();
`ifdef HERLOA_ERR_MON_EN
    chk("d032_err_cnt_inc", err_cnt, c0 + 1);
`endif

    // k clamp
    drive(16'h0300, 16'h0300, 4'd15);
    tick();
    idle();
    tick();
    chk("d033_s", s, 16'h07FF);
    tick();

    // stall with three beats
    out_ready = 1'b0;
    drive(16'h1234, 16'h0F0F, 4'd5);
    tick();
    drive(16'hA5A5, 16'h5A5A, 4'd8);
    tick();
    drive(16'h0300, 16'h0300, 4'd11);
    tick();
    chk("stall_not_accepted", acc, 0);
    chk("stall_in_ready", in_ready, 0);
    tick();
    tick();
    chk("stall_out_valid", out_valid, 1);
    chk("stall_s_hold", s, model(16'h1234, 16'h0F0F, 5).s);
    out_ready = 1'b1;
    tick();
    chk("release_accept", acc, 1);
    idle();
    chk("release_b2_valid", out_valid, 1);
    chk("release_b2_s", s, model(16'hA5A5, 16'h5A5A, 8).s);
    tick();
    chk("release_b3_valid", out_valid, 1);
    chk("release_b3_s", s, 16'h07FF);
    tick();
    chk("release_empty", out_valid, 0);

    // reset with two beats in flight
    out_ready = 1'b0;
    drive(16'h0300, 16'h0300, 4'd11);
    tick();
    drive(16'h00FF, 16'h00FF, 4'd11);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s", s, 0);
    chk("midrst_in_ready", in_ready, 1);
`ifdef HERLOA_ERR_MON_EN
    chk("midrst_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    repeat (4) tick();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a = N'($urandom);
      b = N'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      k = KW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef HERLOA_ERR_MON_EN
      err_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end

    idle();
    out_ready = 1'b1;
`ifdef HERLOA_ERR_MON_EN
    err_clr = 1'b0;
`endif
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/herloa_pipe.md
HERLOA_PIPE -- requirements
Module: herloa_pipe

Interface
REQ-001 SHALL have parameter N, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter KMAX, default 11: largest approximate lower-part width; 0 <= KMAX <= N.
REQ-003 SHALL have parameter KW, default 4: width of the k input; 2^KW > KMAX.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: the a, b and k inputs are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an input this cycle.
REQ-008 SHALL have port a, input, N bits: operand A.
REQ-009 SHALL have port b, input, N bits: operand B.
REQ-010 SHALL have port k, input, KW bits: approximation level for this transaction.
REQ-011 SHALL have port out_valid, output, 1 bit: s and cout are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-013 SHALL have port s, output, N bits: approximate sum.
REQ-014 SHALL have port cout, output, 1 bit: carry out of the upper exact part.

Function
REQ-015 SHALL transfer an input when in_valid and in_ready are both 1, and an output when out_valid and out_ready are both 1.
REQ-016 SHALL be a two-stage pipeline: stage 1 registers the lower approximate sum, the lower carry, the upper operands and k_eff; stage 2 registers the upper exact sum and cout.
REQ-017 SHALL present a result 2 cycles after acceptance when the output is not stalled, and SHALL sustain one transaction per cycle.
REQ-018 SHALL use k_eff = min(k, KMAX) captured per transaction, so k may change on every accepted beat.
REQ-019 SHALL compute the lower part, bits [k_eff-1:0], as follows for k_eff >= 2:
- S[i] = a[i] | b[i] for i < k_eff-1
- S[k_eff-1] = (a[k_eff-1] ^ b[k_eff-1]) | (a[k_eff-2] & b[k_eff-2])
- carry into the upper part = a[k_eff-1] & b[k_eff-1]
REQ-020 SHALL apply error reduction for k_eff >= 3: when a[k_eff-2] & b[k_eff-2] is 1, S[k_eff-3:0] is forced to all ones.
REQ-021 SHALL handle small k_eff:
- k_eff = 1: S[0] = a[0] | b[0], carry = a[0] & b[0]
- k_eff = 0: the whole add is exact with carry-in 0
REQ-022 SHALL compute the upper part, bits [N-1:k_eff], as an exact sum of a, b and the lower carry; cout is the carry out of bit N-1.
REQ-023 SHALL stall the whole pipeline when out_valid = 1 and out_ready = 0: in_ready = 0, and all stage registers hold.
REQ-024 SHALL drive in_ready = !out_valid | out_ready, so that a simultaneous output transfer and input acceptance in the same cycle is allowed with no bubble.
REQ-025 SHALL propagate bubbles (in_valid = 0) as invalid stage entries, so out_valid never asserts for a non-accepted beat.

Reset
REQ-026 SHALL, while rst_n = 0 at a clock edge, clear both stage valid bits; out_valid = 0, s = 0, cout = 0, and in_ready = 1 on the first cycle after reset release.
REQ-027 SHALL discard transactions in flight when reset asserts mid-operation, with no output produced for them.

Configuration
REQ-028 SHALL, with macro HERLOA_ERR_MON_EN defined, add these ports:
- err, output, N+1 bits: |exact (a+b) - approximate {cout,s}|, aligned with s
- err_cnt, output, 16 bits: count of transferred results with err != 0, saturating at 0xFFFF, reset to 0
- err_clr, input, 1 bit: synchronous clear of err_cnt; when a clear coincides with an increment, the clear wins
REQ-029 SHALL, without HERLOA_ERR_MON_EN, omit those ports and all exact-sum logic; s and cout behaviour is unchanged.

Verification (N=16, KMAX=11)
REQ-030 SHALL check a=0x00FF, b=0x00FF, k=11 -> s=0x00FF, cout=0 two cycles later; err=0x00FF when the macro is defined.
REQ-031 SHALL check a=0xFFFF, b=0x0001: k=11 -> s=0xFFFF, cout=0; then k=0 on the next beat -> s=0x0000, cout=1 (back-to-back, no bubble).
REQ-032 SHALL check a=0x0300, b=0x0300, k=11 -> s=0x07FF, cout=0 (error reduction active); err=0x01FF and err_cnt increments by 1.
REQ-033 SHALL check k=15 with a=0x0300, b=0x0300 -> clamped to k_eff=11 -> s=0x07FF.
REQ-034 SHALL check three beats issued with out_ready held 0 -> in_ready drops after the first result is valid, s holds stable; on release the results emerge in order, one per cycle.
REQ-035 SHALL check rst_n pulsed 0 for one cycle with two beats in flight -> out_valid=0 and s=0 after reset, the dropped beats never appear, and err_cnt=0.
